arp_rx: RTL and testbench
=========================

ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 SHALL have one clock, eth_rxck, and an asynchronous active-low reset, rst_rx_n; all state is clocked on the eth_rxck rising edge.
REQ-002 SHALL provide these ports (name  direction  width  meaning):
- eth_rxck  in  1  receive byte clock
- rst_rx_n  in  1  async active-low reset
- rx_d_i  in  9  [8] = frame-valid strobe, [7:0] = frame byte, one byte per cycle, starting at the destination MAC, no preamble or FCS
- myMAC_i  in  48  local MAC address
- myIP_i  in  32  local IPv4 address
- start_o  out  1  one-cycle pulse on an accepted ARP request; drives the ARP reply generator's start input
- DstMAC_o  out  48  sender MAC of the last accepted request
- DstIP_o  out  32  sender IP of the last accepted request
- req_cnt_o  out  16  accepted-request count
- drop_cnt_o  out  16  dropped-frame count

Function
REQ-003 SHALL implement FSM states IDLE, RECV, CHECK, ACCEPT, and FLUSH.
REQ-004 IDLE SHALL go to RECV on a frame start: rx_d_i[8] sampled 1 with the previous sample 0.
- The byte at that edge is byte 0.
- The byte counter (8-bit) SHALL saturate at 255.
REQ-005 RECV SHALL compare bytes on the fly and set a sticky mismatch flag on any failure of these checks:
- bytes 0-5 equal FF:FF:FF:FF:FF:FF or myMAC_i
- bytes 12-13 = 08 06
- bytes 14-15 = 00 01
- bytes 16-17 = 08 00
- byte 18 = 06
- byte 19 = 04
- bytes 20-21 = 00 01 (request)
- bytes 38-41 = myIP_i
REQ-006 RECV SHALL capture bytes 22-27 (sender MAC) and 28-31 (sender IP) into shadow registers, MSB first.
REQ-007 RECV SHALL go to CHECK at the first edge where rx_d_i[8] is sampled 0.
REQ-008 CHECK SHALL go to ACCEPT if the mismatch flag is 0 and the byte count is >= 42.
- Otherwise it SHALL go to IDLE and increment drop_cnt_o.
- A runt frame (< 42 bytes) SHALL count as a drop.
REQ-009 ACCEPT SHALL do all of the following for exactly one cycle, then go to IDLE:
- assert start_o
- copy the shadow registers into DstMAC_o and DstIP_o in the same cycle start_o rises
- increment req_cnt_o
REQ-010 Latency: start_o SHALL be high in the cycle following the second edge after the first rx_d_i[8]=0 sample, i.e. 2 edges after end of frame.
REQ-011 DstMAC_o and DstIP_o SHALL hold their values until the next ACCEPT; dropped frames SHALL NOT alter them.
REQ-012 A frame start seen while in CHECK or ACCEPT SHALL be ignored; the FSM SHALL then go to FLUSH instead of IDLE and increment drop_cnt_o.
REQ-013 FLUSH SHALL wait until rx_d_i[8] is sampled 0, then go to IDLE.
REQ-014 Counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-015 Bytes beyond 41 SHALL be ignored for the compare; padding content is don't-care.
REQ-016 myMAC_i and myIP_i SHALL be treated as quasi-static and sampled at each compare.

Reset
REQ-017 While rst_rx_n = 0, the block SHALL hold:
- FSM = IDLE
- start_o = 0
- DstMAC_o = 0
- DstIP_o = 0
- req_cnt_o = 0
- drop_cnt_o = 0
- mismatch flag and byte counter cleared
REQ-018 If rx_d_i[8] = 1 at reset release, the FSM SHALL enter FLUSH; the partial frame SHALL NOT be parsed or counted.

Verification
Setup for all scenarios: myMAC_i = 00:0A:35:02:0F:B0, myIP_i = C0A8010A.
REQ-019 Broadcast ARP request, 60 bytes:
- Stimulus: sender 11:22:33:44:55:66 / C0A80102, target IP C0A8010A.
- Response: one start_o pulse 2 edges after end of frame; DstMAC_o = 112233445566; DstIP_o = C0A80102; req_cnt_o = 1.
REQ-020 Same frame with target IP C0A8010B:
- Response: no start_o; drop_cnt_o = 1; DstMAC_o and DstIP_o unchanged.
REQ-021 Frame with OPER = 00 02 (reply), then a frame with ethertype 08 00:
- Response: no start_o; drop_cnt_o = 2.
REQ-022 Valid request header truncated to 40 bytes:
- Response: drop_cnt_o increments by 1; no start_o.
REQ-023 Two valid requests separated by a one-cycle valid gap:
- Response: first accepted; second start falls in CHECK/ACCEPT, is flushed and counted as a drop.
- Then a third request after 2 idle cycles: accepted; req_cnt_o = 2.
REQ-024 Reset asserted at byte 20 of a valid request and released at byte 30:
- Response: all outputs 0; FLUSH until valid falls; no start_o; counters remain 0.

Source files
------------

// File: rtl/arp_rx_if.sv
// Receive-side ARP bus: byte stream and local address inputs in, reply trigger,
// captured sender addresses and counters out.
interface arp_rx_if;
    logic [8:0]  rx_d_i;
    logic [47:0] myMAC_i;
    logic [31:0] myIP_i;
    logic        start_o;
    logic [47:0] DstMAC_o;
    logic [31:0] DstIP_o;
    logic [15:0] req_cnt_o;
    logic [15:0] drop_cnt_o;

    modport master (
        output rx_d_i, myMAC_i, myIP_i,
        input  start_o, DstMAC_o, DstIP_o, req_cnt_o, drop_cnt_o
    );

    modport slave (
        input  rx_d_i, myMAC_i, myIP_i,
        output start_o, DstMAC_o, DstIP_o, req_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/arp_rx.sv
// ARP request receiver: checks each frame on the fly, captures the sender addresses
// and fires a one-cycle start pulse for requests aimed at our IP.
module arp_rx (
    input  logic     eth_rxck,
    input  logic     rst_rx_n,
    arp_rx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RECV, CHECK, ACCEPT, FLUSH} state_t;

    state_t      r_state, w_next;
    logic        r_prev_valid;
    logic [7:0]  r_cnt;
    logic        r_mismatch, r_not_bcast, r_not_mine, r_flush_pend;
    logic [47:0] r_sh_mac, r_dst_mac;
    logic [31:0] r_sh_ip, r_dst_ip;
    logic        r_start;
    logic [15:0] r_req_cnt, r_drop_cnt;

    logic        w_valid, w_frame_start, w_take, w_frame_ok;
    logic [7:0]  w_byte, w_idx, w_exp, w_mac_byte;
    logic        w_chk, w_da, w_hdr_fail, w_bc_fail, w_mine_fail;
    logic        w_accept;
    logic [1:0]  w_drop_inc;
    logic [16:0] w_drop_sum;
    logic [15:0] w_drop_next;

    assign w_valid       = bus.rx_d_i[8];
    assign w_byte        = bus.rx_d_i[7:0];
    assign w_frame_start = w_valid & ~r_prev_valid;
    assign w_take        = ((r_state == IDLE) && w_frame_start) || ((r_state == RECV) && w_valid);
    assign w_idx         = (r_state == IDLE) ? 8'd0 : r_cnt;

    always_comb begin
        w_chk      = 1'b0;
        w_exp      = 8'h00;
        w_da       = 1'b0;
        w_mac_byte = 8'h00;
        case (w_idx)
            8'd0:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[47:40]; end
            8'd1:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[39:32]; end
            8'd2:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[31:24]; end
            8'd3:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[23:16]; end
            8'd4:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[15:8];  end
            8'd5:  begin w_da = 1'b1; w_mac_byte = bus.myMAC_i[7:0];   end
            8'd12: begin w_chk = 1'b1; w_exp = 8'h08; end
            8'd13: begin w_chk = 1'b1; w_exp = 8'h06; end
            8'd14: begin w_chk = 1'b1; w_exp = 8'h00; end
            8'd15: begin w_chk = 1'b1; w_exp = 8'h01; end
            8'd16: begin w_chk = 1'b1; w_exp = 8'h08; end
            8'd17: begin w_chk = 1'b1; w_exp = 8'h00; end
            8'd18: begin w_chk = 1'b1; w_exp = 8'h06; end
            8'd19: begin w_chk = 1'b1; w_exp = 8'h04; end
            8'd20: begin w_chk = 1'b1; w_exp = 8'h00; end
            8'd21: begin w_chk = 1'b1; w_exp = 8'h01; end
            8'd38: begin w_chk = 1'b1; w_exp = bus.myIP_i[31:24]; end
            8'd39: begin w_chk = 1'b1; w_exp = bus.myIP_i[23:16]; end
            8'd40: begin w_chk = 1'b1; w_exp = bus.myIP_i[15:8];  end
            8'd41: begin w_chk = 1'b1; w_exp = bus.myIP_i[7:0];   end
            default: ;
        endcase
    end

    assign w_hdr_fail  = w_chk && (w_byte != w_exp);
    assign w_bc_fail   = w_da && (w_byte != 8'hFF);
    assign w_mine_fail = w_da && (w_byte != w_mac_byte);
    // Destination is fine if it matched broadcast or our MAC over all six bytes
    assign w_frame_ok  = ~r_mismatch & ~(r_not_bcast & r_not_mine) & (r_cnt >= 8'd42);

    always_ff @(posedge eth_rxck or negedge rst_rx_n) begin
        if (!rst_rx_n) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // Valid already high in IDLE only happens right after reset: skip that partial frame
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_drop_inc = 2'd0;
        case (r_state)
            IDLE:   if (w_valid) w_next = r_prev_valid ? FLUSH : RECV;
            RECV:   if (!w_valid) w_next = CHECK;
            CHECK: begin
                if (w_frame_ok) begin
                    w_next = ACCEPT;
                end else begin
                    w_next     = w_frame_start ? FLUSH : IDLE;
                    w_drop_inc = w_frame_start ? 2'd2 : 2'd1;
                end
            end
            ACCEPT: begin
                w_accept = 1'b1;
                if (r_flush_pend || w_frame_start) begin
                    w_next     = FLUSH;
                    w_drop_inc = 2'd1;
                end else begin
                    w_next = IDLE;
                end
            end
            FLUSH:  if (!w_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    always_ff @(posedge eth_rxck or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            r_prev_valid <= 1'b1;
            r_cnt        <= 8'd0;
            r_mismatch   <= 1'b0;
            r_not_bcast  <= 1'b0;
            r_not_mine   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_sh_mac     <= 48'd0;
            r_sh_ip      <= 32'd0;
            r_start      <= 1'b0;
            r_dst_mac    <= 48'd0;
            r_dst_ip     <= 32'd0;
            r_req_cnt    <= 16'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            r_prev_valid <= w_valid;
            r_start      <= w_accept;
            r_flush_pend <= (r_state == CHECK) && w_frame_start;
            r_drop_cnt   <= w_drop_next;
            if (w_take) begin
                r_cnt       <= (r_state == IDLE) ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
                r_mismatch  <= ((r_state != IDLE) && r_mismatch)  | w_hdr_fail;
                r_not_bcast <= ((r_state != IDLE) && r_not_bcast) | w_bc_fail;
                r_not_mine  <= ((r_state != IDLE) && r_not_mine)  | w_mine_fail;
                if (w_idx >= 8'd22 && w_idx <= 8'd27) r_sh_mac <= {r_sh_mac[39:0], w_byte};
                if (w_idx >= 8'd28 && w_idx <= 8'd31) r_sh_ip  <= {r_sh_ip[23:0], w_byte};
            end
            if (w_accept) begin
                r_dst_mac <= r_sh_mac;
                r_dst_ip  <= r_sh_ip;
                r_req_cnt <= (r_req_cnt == 16'hFFFF) ? r_req_cnt : r_req_cnt + 16'd1;
            end
        end
    end

    assign bus.start_o    = r_start;
    assign bus.DstMAC_o   = r_dst_mac;
    assign bus.DstIP_o    = r_dst_ip;
    assign bus.req_cnt_o  = r_req_cnt;
    assign bus.drop_cnt_o = r_drop_cnt;
endmodule

// File: tb/tb_arp_rx.sv
// Randomized bench for arp_rx: whole-frame reference model decides accept/drop
// and tracks the expected counters and captured sender addresses.
module tb_arp_rx;
    localparam logic [47:0] MY_MAC = 48'h000A35020FB0;
    localparam logic [31:0] MY_IP  = 32'hC0A8010A;
    localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

    logic clk = 1'b0;
    logic rst_n;
    arp_rx_if bus();

    arp_rx dut (
        .eth_rxck (clk),
        .rst_rx_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errCount   = 0;
    int cyc        = 0;
    int pulses     = 0;
    int lastStartCyc = -1;
    int endCyc     = 0;
    logic [7:0] frame[$];
    int expReq = 0, expDrop = 0;
    logic [47:0] expMac = 48'd0;
    logic [31:0] expIp  = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.start_o === 1'b1) begin
            pulses++;
            lastStartCyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic buildFrame(input logic [47:0] da, input logic [47:0] smac, input logic [31:0] sip,
                              input logic [31:0] tip, input logic [15:0] etype, input logic [15:0] oper,
                              input int len);
        frame.delete();
        for (int i = 0; i < ((len > 60) ? len : 60); i++) frame.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) begin
            frame[i]      = da[47-8*i -: 8];
            frame[22 + i] = smac[47-8*i -: 8];
            frame[32 + i] = 8'h00;
        end
        frame[12] = etype[15:8];
        frame[13] = etype[7:0];
        frame[14] = 8'h00; frame[15] = 8'h01;
        frame[16] = 8'h08; frame[17] = 8'h00;
        frame[18] = 8'h06; frame[19] = 8'h04;
        frame[20] = oper[15:8];
        frame[21] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            frame[28 + i] = sip[31-8*i -: 8];
            frame[38 + i] = tip[31-8*i -: 8];
        end
        while (frame.size() > len) void'(frame.pop_back());
    endtask

    // Reference decision taken on the complete frame
    function automatic bit modelAccept();
        logic [7:0] hdr [10];
        bit bc = 1'b1;
        bit mine = 1'b1;
        hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        if (frame.size() < 42) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (frame[i] != 8'hFF) bc = 1'b0;
            if (frame[i] != MY_MAC[47-8*i -: 8]) mine = 1'b0;
        end
        if (!(bc || mine)) return 1'b0;
        for (int i = 0; i < 10; i++) if (frame[12 + i] != hdr[i]) return 1'b0;
        for (int i = 0; i < 4; i++) if (frame[38 + i] != MY_IP[31-8*i -: 8]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [47:0] frameMac();
        logic [47:0] m = 48'd0;
        for (int i = 22; i < 28; i++) m = {m[39:0], frame[i]};
        return m;
    endfunction

    function automatic logic [31:0] frameIp();
        logic [31:0] p = 32'd0;
        for (int i = 28; i < 32; i++) p = {p[23:0], frame[i]};
        return p;
    endfunction

    task automatic applyStimulus(input int gap);
        foreach (frame[i]) begin
            @(negedge clk);
            bus.rx_d_i = {1'b1, frame[i]};
        end
        @(negedge clk);
        bus.rx_d_i = 9'd0;
        endCyc = cyc + 1;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_mac"},  64'(bus.DstMAC_o),   64'(expMac));
        checkOutput({tag, "_ip"},   64'(bus.DstIP_o),    64'(expIp));
        checkOutput({tag, "_req"},  64'(bus.req_cnt_o),  64'(expReq));
        checkOutput({tag, "_drop"}, 64'(bus.drop_cnt_o), 64'(expDrop));
    endtask

    task automatic runFrame(input string tag);
        bit acc;
        int p0;
        acc = modelAccept();
        p0  = pulses;
        applyStimulus(6);
        if (acc) begin
            expReq++;
            expMac = frameMac();
            expIp  = frameIp();
        end else begin
            expDrop++;
        end
        checkOutput({tag, "_pulse"}, 64'(pulses - p0), acc ? 64'd1 : 64'd0);
        if (acc) checkOutput({tag, "_lat"}, 64'(lastStartCyc - endCyc), 64'd2);
        checkState(tag);
    endtask

    initial begin
        int kind, len, idx, p0;
        int chkIdx [14];
        logic [47:0] da, smac;
        logic [31:0] sip;
        chkIdx = '{12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 38, 39, 40, 41};

        rst_n = 1'b0;
        bus.rx_d_i  = 9'd0;
        bus.myMAC_i = MY_MAC;
        bus.myIP_i  = MY_IP;
        repeat (3) @(negedge clk);
        checkOutput("rst_start", 64'(bus.start_o), 64'd0);
        checkState("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        buildFrame(BCAST, 48'h112233445566, 32'hC0A80102, MY_IP, 16'h0806, 16'h0001, 60);
        runFrame("bcast_req");
        checkOutput("bcast_req_mac_k", 64'(bus.DstMAC_o), 64'h112233445566);
        checkOutput("bcast_req_ip_k",  64'(bus.DstIP_o),  64'hC0A80102);

        buildFrame(BCAST, 48'hA1A2A3A4A5A6, 32'hC0A80177, 32'hC0A8010B, 16'h0806, 16'h0001, 60);
        runFrame("wrong_tip");
        buildFrame(BCAST, 48'hA1A2A3A4A5A6, 32'hC0A80177, MY_IP, 16'h0806, 16'h0002, 60);
        runFrame("oper_reply");
        buildFrame(BCAST, 48'hA1A2A3A4A5A6, 32'hC0A80177, MY_IP, 16'h0800, 16'h0001, 60);
        runFrame("etype_ip");
        checkOutput("etype_ip_drop_k", 64'(bus.drop_cnt_o), 64'd3);
        buildFrame(BCAST, 48'hA1A2A3A4A5A6, 32'hC0A80177, MY_IP, 16'h0806, 16'h0001, 40);
        runFrame("runt40");

        p0 = pulses;
        buildFrame(BCAST, 48'h0102030405A0, 32'hC0A80120, MY_IP, 16'h0806, 16'h0001, 60);
        applyStimulus(1);
        buildFrame(BCAST, 48'h0102030405B0, 32'hC0A80121, MY_IP, 16'h0806, 16'h0001, 60);
        applyStimulus(2);
        buildFrame(MY_MAC, 48'h0102030405C0, 32'hC0A80122, MY_IP, 16'h0806, 16'h0001, 60);
        applyStimulus(6);
        expReq += 2;
        expDrop += 1;
        expMac = 48'h0102030405C0;
        expIp  = 32'hC0A80122;
        checkOutput("b2b_pulse", 64'(pulses - p0), 64'd2);
        checkOutput("b2b_lat", 64'(lastStartCyc - endCyc), 64'd2);
        checkState("b2b");

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            smac = {16'($urandom), 32'($urandom)};
            sip  = $urandom;
            da   = BCAST;
            len  = 60;
            case (kind)
                1: da = MY_MAC;
                2: da = ($urandom_range(0, 1) == 1) ? {24'hFFFFFF, MY_MAC[23:0]}
                                                    : (MY_MAC ^ (48'd1 << $urandom_range(0, 47)));
                4: len = $urandom_range(20, 41);
                5: len = $urandom_range(43, 90);
                6: len = 42;
                default: ;
            endcase
            buildFrame(da, smac, sip, MY_IP, 16'h0806, 16'h0001, len);
            if (kind == 3) begin
                idx = chkIdx[$urandom_range(0, 13)];
                frame[idx] = frame[idx] ^ 8'($urandom_range(1, 255));
            end
            if (kind == 7) begin
                idx = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 11) : $urandom_range(32, 37);
                frame[idx] = frame[idx] ^ 8'($urandom_range(1, 255));
            end
            runFrame("rand");
        end

        p0 = pulses;
        buildFrame(BCAST, 48'h112233445566, 32'hC0A80102, MY_IP, 16'h0806, 16'h0001, 60);
        foreach (frame[i]) begin
            @(negedge clk);
            if (i == 20) rst_n = 1'b0;
            if (i == 30) rst_n = 1'b1;
            bus.rx_d_i = {1'b1, frame[i]};
            if (i == 25) begin
                expReq = 0; expDrop = 0; expMac = 48'd0; expIp = 32'd0;
                checkOutput("midrst_start", 64'(bus.start_o), 64'd0);
                checkState("midrst_in");
            end
        end
        @(negedge clk);
        bus.rx_d_i = 9'd0;
        repeat (6) @(negedge clk);
        checkOutput("midrst_pulse", 64'(pulses - p0), 64'd0);
        checkState("midrst_after");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
